// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define RX_MAJORITY_VOTE_EN to decide each bit by 2-of-3 vote around the bit centre.
module uart_rx_frame #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [PRESC_WIDTH-1:0] PRESCALE,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  output logic [DATA_WIDTH-1:0]  P_DATA,
  output logic                   DATA_VALID,
  output logic                   PAR_ERR,
  output logic                   STP_ERR,
  output logic                   BUSY
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [PRESC_WIDTH-1:0] ONE     = 1;
  localparam logic [BCW-1:0]         BIT_ONE = 1;
  localparam logic [BCW-1:0]         N_BITS  = BCW'(DATA_WIDTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                   sync_1, rx_s;
  logic [2:0]             state;
  logic [PRESC_WIDTH-1:0] edge_cnt, presc_r, mid;
  logic [BCW-1:0]         bit_cnt;
  logic                   par_en_r, par_typ_r, par_bad;
  logic                   samp_mid, bit_val;
  logic [DATA_WIDTH-1:0]  shreg;
  logic                   at_decide, at_wrap;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= RX_IN;
      rx_s   <= sync_1;
    end
  end

  assign mid       = presc_r >> 1;
  assign at_decide = (edge_cnt == mid + ONE);
  assign at_wrap   = (edge_cnt == presc_r - ONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  samp_mid <= 1'b1;
    else if (edge_cnt == mid) samp_mid <= rx_s;
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic samp_lo;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        samp_lo <= 1'b1;
    else if (edge_cnt == mid - ONE) samp_lo <= rx_s;
  end

  // NOTE: always_comb assigns bit_val on every path, so no latch is inferred.
  always_comb begin
    bit_val = (samp_lo & samp_mid) | (samp_lo & rx_s) | (samp_mid & rx_s);
  end
`else
  always_comb begin
    bit_val = samp_mid;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      presc_r    <= '0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      par_bad    <= 1'b0;
      shreg      <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (state != ST_IDLE) edge_cnt <= at_wrap ? '0 : edge_cnt + ONE;

      case (state)
        ST_IDLE: begin
          // The detection cycle counts as edge 0 of the start bit.
          if (!rx_s) begin
            state     <= ST_START;
            edge_cnt  <= ONE;
            presc_r   <= PRESCALE;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
            par_bad   <= 1'b0;
            bit_cnt   <= '0;
            BUSY      <= 1'b1;
          end
        end
        ST_START: begin
          if (at_decide && bit_val) begin
            state    <= ST_IDLE;
            edge_cnt <= '0;
            BUSY     <= 1'b0;
          end else if (at_wrap) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (at_decide) begin
            shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + BIT_ONE;
          end else if (at_wrap && bit_cnt == N_BITS) begin
            state <= par_en_r ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (at_decide)    par_bad <= (bit_val != ((^shreg) ^ par_typ_r));
          else if (at_wrap) state   <= ST_STOP;
        end
        ST_STOP: begin
          // Leave at the decision so a back-to-back start edge is not missed.
          if (at_decide) begin
            state    <= ST_IDLE;
            edge_cnt <= '0;
            BUSY     <= 1'b0;
            STP_ERR  <= ~bit_val;
            PAR_ERR  <= par_bad;
            if (!par_bad && bit_val) begin
              P_DATA     <= shreg;
              DATA_VALID <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          edge_cnt <= '0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule
